// File: rtl/mem_rmw_ctrl.sv
// rtl/mem_rmw_ctrl.sv - data-memory access controller with sub-word read-modify-write
// Sits in front of a word-only RAM; sub-word stores merge into the word read back one cycle earlier.
module mem_rmw_ctrl #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        ram_wr_en_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state, state_nxt;
  logic        we_q, uns_q, err_q, req_err, accept;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  logic [31:0] wr_word, lane_shifted, load_word;

  assign accept = (state == S_IDLE) && req_i;

  always_comb begin
    req_err = (size_i == 2'b11)
           || (size_i == 2'b01 && addr_i[0])
           || (size_i == 2'b10 && addr_i[1:0] != 2'b00)
           || (addr_i[31:2] >= WORD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_i) begin
          if (req_err)              state_nxt = S_DONE;
          else if (!we_i)           state_nxt = S_LOAD;
          else if (size_i == 2'b10) state_nxt = S_WRITE;
          else                      state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_WRITE;
      S_LOAD:  state_nxt = S_DONE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write and done are gated by rst so an abandoned access leaves no trace.
  always_comb begin
    ready_o     = (state == S_IDLE);
    done_o      = (state == S_DONE) && !rst;
    err_o       = (state == S_DONE) && !rst && err_q;
    ram_wr_en_o = (state == S_WRITE) && !rst;
    ram_data_o  = (state == S_WRITE) ? wr_word : 32'h0;
  end

  always_comb begin
    wr_word = merge_q;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0: wr_word[7:0]   = wdata_q[7:0];
        2'd1: wr_word[15:8]  = wdata_q[7:0];
        2'd2: wr_word[23:16] = wdata_q[7:0];
        default: wr_word[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
      else           wr_word[15:0]  = wdata_q[15:0];
    end else begin
      wr_word = wdata_q;
    end
  end

  always_comb begin
    lane_shifted = ram_data_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_word = uns_q ? {24'h0, lane_shifted[7:0]}
                                 : {{24{lane_shifted[7]}}, lane_shifted[7:0]};
      2'b01:   load_word = uns_q ? {16'h0, lane_shifted[15:0]}
                                 : {{16{lane_shifted[15]}}, lane_shifted[15:0]};
      default: load_word = ram_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        err_q   <= req_err;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state == S_READ) merge_q <= ram_data_i;
      if (state == S_LOAD) rdata_q <= load_word;
    end
  end

  assign rdata_o    = rdata_q;
  assign ram_addr_o = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// tb/tb_mem_rmw_ctrl.sv - directed self-checking bench for mem_rmw_ctrl
// A behavioural word RAM answers reads combinationally and records every write.
module tb_mem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic        ready_o, done_o, err_o, ram_wr_en_o;
  logic [31:0] rdata_o, ram_addr_o, ram_data_o, ram_data_i;

  logic [31:0] mem [0:4095];
  int          wr_count = 0;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_rmw_ctrl #(.MEM_WORDS(4096)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i)
  );

  assign ram_data_i = mem[ram_addr_o[13:2]];

  always @(posedge clk) begin
    if (ram_wr_en_o) begin
      mem[ram_addr_o[13:2]] = ram_data_o;
      wr_count = wr_count + 1;
      last_wr_addr = ram_addr_o;
      last_wr_data = ram_data_o;
    end
  end

  // Issues one request in cycle T; lat is the cycle offset of done_o, -1 if none within budget.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err);
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
    lat = -1;
    err = 1'bx;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_i = 1'b0;
      if (done_o === 1'b1) begin
        lat = k;
        err = err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    total++; if (ram_wr_en_o !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", ram_wr_en_o); end
    total++; if (ram_addr_o !== 32'h0) begin bad++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr_o); end
    total++; if (ram_data_o !== 32'h0) begin bad++; $display("FAIL reset_ram_data got=%h exp=0", ram_data_o); end
  endtask

  task automatic test_word();
    int lat; logic err; int w0;
    w0 = wr_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err);
    total++; if (lat !== 2 || err !== 1'b0) begin bad++; $display("FAIL word_store_lat got=%0d/%b exp=2/0", lat, err); end
    total++; if (wr_count - w0 !== 1) begin bad++; $display("FAIL word_store_writes got=%0d exp=1", wr_count - w0); end
    total++; if (last_wr_addr !== 32'h10 || last_wr_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL word_store_data got=%h@%h exp=deadbeef@10", last_wr_data, last_wr_addr); end
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, err);
    total++; if (lat !== 2 || err !== 1'b0) begin bad++; $display("FAIL word_load_lat got=%0d/%b exp=2/0", lat, err); end
    total++; if (rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load_data got=%h exp=deadbeef", rdata_o); end
    total++; if (ram_addr_o !== 32'h10) begin bad++; $display("FAIL ram_addr_hold got=%h exp=10", ram_addr_o); end
  endtask

  task automatic test_byte();
    int lat; logic err;
    mem[4] = 32'h11223344;
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFFA5, lat, err);
    total++; if (lat !== 3 || err !== 1'b0) begin bad++; $display("FAIL byte_store_lat got=%0d/%b exp=3/0", lat, err); end
    total++; if (last_wr_data !== 32'hA5223344) begin bad++; $display("FAIL byte_store_merge got=%h exp=a5223344", last_wr_data); end
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, err);
    total++; if (rdata_o !== 32'hFFFFFFA5) begin bad++; $display("FAIL byte_load_signed got=%h exp=ffffffa5", rdata_o); end
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, err);
    total++; if (rdata_o !== 32'h000000A5) begin bad++; $display("FAIL byte_load_unsigned got=%h exp=000000a5", rdata_o); end
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, err);
    total++; if (rdata_o !== 32'h00000022) begin bad++; $display("FAIL byte_load_lane2 got=%h exp=00000022", rdata_o); end
  endtask

  task automatic test_half();
    int lat; logic err;
    mem[8] = 32'h0;
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h12348001, lat, err);
    total++; if (lat !== 3 || err !== 1'b0) begin bad++; $display("FAIL half_store_lat got=%0d/%b exp=3/0", lat, err); end
    total++; if (mem[8] !== 32'h80010000) begin bad++; $display("FAIL half_store_merge got=%h exp=80010000", mem[8]); end
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, err);
    total++; if (rdata_o !== 32'hFFFF8001) begin bad++; $display("FAIL half_load_signed got=%h exp=ffff8001", rdata_o); end
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, err);
    total++; if (rdata_o !== 32'h00008001) begin bad++; $display("FAIL half_load_unsigned got=%h exp=00008001", rdata_o); end
  endtask

  task automatic test_errors();
    int lat; logic err; int w0;
    logic [31:0] rd_before;
    w0 = wr_count;
    rd_before = rdata_o;
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, err);
    total++; if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL err_misaligned_word got=%0d/%b exp=1/1", lat, err); end
    do_req(1'b1, 2'b01, 1'b0, 32'h09, 32'h1234, lat, err);
    total++; if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL err_misaligned_half got=%0d/%b exp=1/1", lat, err); end
    do_req(1'b1, 2'b11, 1'b0, 32'h00, 32'h55, lat, err);
    total++; if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL err_size11 got=%0d/%b exp=1/1", lat, err); end
    do_req(1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFEF00D, lat, err);
    total++; if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL err_range got=%0d/%b exp=1/1", lat, err); end
    total++; if (wr_count !== w0) begin bad++; $display("FAIL err_no_write got=%0d exp=%0d", wr_count, w0); end
    total++; if (rdata_o !== rd_before) begin bad++; $display("FAIL err_rdata_held got=%h exp=%h", rdata_o, rd_before); end
    do_req(1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hCAFEF00D, lat, err);
    total++; if (lat !== 2 || err !== 1'b0 || mem[4095] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL top_word_store got=%0d/%b/%h exp=2/0/cafef00d", lat, err, mem[4095]); end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    w0 = wr_count;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 32'h11; wdata_i = 32'h5A;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (ram_wr_en_o !== 1'b0) begin bad++; $display("FAIL rst_write_gated got=%b exp=0", ram_wr_en_o); end
    @(negedge clk);
    rst = 1'b0;
    total++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL rst_after ready/done got=%b/%b exp=1/0", ready_o, done_o); end
    @(negedge clk);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%b exp=0", done_o); end
    total++; if (wr_count !== w0 || mem[4] !== 32'hA5223344) begin
      bad++; $display("FAIL rst_ram_unchanged got=%0d/%h exp=%0d/a5223344", wr_count, mem[4], w0); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata_cleared got=%h exp=0", rdata_o); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    rst = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
